// File: rtl/cell_sweep_pkg.sv
// Shared types and default sizing for the cell mux / ring-osc characterisation sweep.
// Optional abort input is enabled by defining CELL_SWEEP_ABORT_EN.
package cell_sweep_pkg;

  localparam int DEF_PAGE_W        = 6;
  localparam int DEF_SEL_W         = 3;
  localparam int DEF_CNT_W         = 8;
  localparam int DEF_SETTLE_CYCLES = 4;
  localparam int DEF_GATE_CYCLES   = 16;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_ARM,
    ST_CAPTURE,
    ST_EMIT,
    ST_DONE
  } sweep_state_t;

  function automatic int maxOf(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/cell_sweep_iter.sv
// Next-set-bit finder over the select mask: the lowest set bit above i_cur,
// plus the lowest set bit overall for restarting on a new page.
module cell_sweep_iter
  import cell_sweep_pkg::*;
#(
  parameter int SEL_W = DEF_SEL_W
) (
  input  logic [2**SEL_W-1:0] i_mask,
  input  logic [SEL_W-1:0]    i_cur,
  output logic [SEL_W-1:0]    o_next,
  output logic                o_found,
  output logic [SEL_W-1:0]    o_lowest
);

  localparam int NSEL = 2**SEL_W;

  // Scanning downward lets the last hit win, so both outputs end on the lowest match.
  always_comb begin
    o_next   = '0;
    o_found  = 1'b0;
    o_lowest = '0;
    for (int i = NSEL - 1; i >= 0; i--) begin
      if (i_mask[i]) begin
        o_lowest = SEL_W'(i);
        if (i > int'(i_cur)) begin
          o_next  = SEL_W'(i);
          o_found = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/cell_sweep_ctrl.sv
// Sweep sequencer: per page and per selected mux output, settle, gate the ring-osc
// timer, capture the count and emit a record. Define CELL_SWEEP_ABORT_EN to add 'abort'.
module cell_sweep_ctrl
  import cell_sweep_pkg::*;
#(
  parameter int PAGE_W        = DEF_PAGE_W,
  parameter int SEL_W         = DEF_SEL_W,
  parameter int CNT_W         = DEF_CNT_W,
  parameter int SETTLE_CYCLES = DEF_SETTLE_CYCLES,
  parameter int GATE_CYCLES   = DEF_GATE_CYCLES
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [PAGE_W-1:0]   page_first,
  input  logic [PAGE_W-1:0]   page_last,
  input  logic [2**SEL_W-1:0] sel_mask,
  input  logic [PAGE_W-1:0]   cm_in_cfg,
`ifdef CELL_SWEEP_ABORT_EN
  input  logic                abort,
`endif
  output logic [PAGE_W-1:0]   cm_page,
  output logic [PAGE_W-1:0]   cm_in,
  output logic                ro_en,
  output logic [SEL_W-1:0]    ro_sel,
  input  logic [CNT_W-1:0]    ro_count,
  output logic                res_valid,
  input  logic                res_ready,
  output logic [PAGE_W-1:0]   res_page,
  output logic [SEL_W-1:0]    res_sel,
  output logic [CNT_W-1:0]    res_count,
  output logic                busy,
  output logic                done
);

  localparam int NSEL  = 2**SEL_W;
  localparam int TMR_W = $clog2(maxOf(SETTLE_CYCLES, GATE_CYCLES)) + 1;
  localparam logic [TMR_W-1:0] SETTLE_LAST = TMR_W'(SETTLE_CYCLES - 1);
  localparam logic [TMR_W-1:0] GATE_LAST   = TMR_W'(GATE_CYCLES - 1);

  sweep_state_t      r_state;
  logic [TMR_W-1:0]  r_timer;
  logic [PAGE_W-1:0] r_pageLast;
  logic [NSEL-1:0]   r_selMask;
  logic [PAGE_W-1:0] r_cmPage;
  logic [PAGE_W-1:0] r_cmIn;
  logic              r_roEn;
  logic [SEL_W-1:0]  r_roSel;
  logic              r_resValid;
  logic [PAGE_W-1:0] r_resPage;
  logic [SEL_W-1:0]  r_resSel;
  logic [CNT_W-1:0]  r_resCount;
  logic              r_busy;
  logic              r_done;

  logic [NSEL-1:0]   w_iterMask;
  logic [SEL_W-1:0]  w_nextSel;
  logic              w_found;
  logic [SEL_W-1:0]  w_lowestSel;
  logic              w_abort;

`ifdef CELL_SWEEP_ABORT_EN
  assign w_abort = abort;
`else
  assign w_abort = 1'b0;
`endif

  // In IDLE the live mask is scanned so the first select is ready at the start edge.
  assign w_iterMask = (r_state == ST_IDLE) ? sel_mask : r_selMask;

  cell_sweep_iter #(
    .SEL_W(SEL_W)
  ) u_iter (
    .i_mask  (w_iterMask),
    .i_cur   (r_roSel),
    .o_next  (w_nextSel),
    .o_found (w_found),
    .o_lowest(w_lowestSel)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_timer    <= '0;
      r_pageLast <= '0;
      r_selMask  <= '0;
      r_cmPage   <= '0;
      r_cmIn     <= '0;
      r_roEn     <= 1'b0;
      r_roSel    <= '0;
      r_resValid <= 1'b0;
      r_resPage  <= '0;
      r_resSel   <= '0;
      r_resCount <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
    end else if (w_abort && r_state != ST_IDLE && r_state != ST_DONE) begin
      r_roEn     <= 1'b0;
      r_resValid <= 1'b0;
      r_done     <= 1'b1;
      r_state    <= ST_DONE;
    end else begin
      r_done <= 1'b0;
      unique case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_pageLast <= page_last;
            r_selMask  <= sel_mask;
            r_cmIn     <= cm_in_cfg;
            r_busy     <= 1'b1;
            if (page_first > page_last || sel_mask == '0) begin
              r_done  <= 1'b1;
              r_state <= ST_DONE;
            end else begin
              r_cmPage <= page_first;
              r_roSel  <= w_lowestSel;
              r_timer  <= '0;
              r_state  <= ST_SETUP;
            end
          end
        end
        ST_SETUP: begin
          if (r_timer == SETTLE_LAST) begin
            r_timer <= '0;
            r_roEn  <= 1'b1;
            r_state <= ST_ARM;
          end else begin
            r_timer <= r_timer + 1'b1;
          end
        end
        ST_ARM: begin
          if (r_timer == GATE_LAST) begin
            r_timer <= '0;
            r_roEn  <= 1'b0;
            r_state <= ST_CAPTURE;
          end else begin
            r_timer <= r_timer + 1'b1;
          end
        end
        ST_CAPTURE: begin
          r_resCount <= ro_count;
          r_resPage  <= r_cmPage;
          r_resSel   <= r_roSel;
          r_resValid <= 1'b1;
          r_state    <= ST_EMIT;
        end
        ST_EMIT: begin
          // Compare before incrementing so page_last at the top of the range never wraps.
          if (res_ready) begin
            r_resValid <= 1'b0;
            r_timer    <= '0;
            if (w_found) begin
              r_roSel <= w_nextSel;
              r_state <= ST_SETUP;
            end else if (r_cmPage < r_pageLast) begin
              r_cmPage <= r_cmPage + 1'b1;
              r_roSel  <= w_lowestSel;
              r_state  <= ST_SETUP;
            end else begin
              r_done  <= 1'b1;
              r_state <= ST_DONE;
            end
          end
        end
        ST_DONE: begin
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign cm_page   = r_cmPage;
  assign cm_in     = r_cmIn;
  assign ro_en     = r_roEn;
  assign ro_sel    = r_roSel;
  assign res_valid = r_resValid;
  assign res_page  = r_resPage;
  assign res_sel   = r_resSel;
  assign res_count = r_resCount;
  assign busy      = r_busy;
  assign done      = r_done;

endmodule

// File: tb/tb_cell_sweep_ctrl.sv
// Directed bench for cell_sweep_ctrl with default parameters; covers the abort
// input when CELL_SWEEP_ABORT_EN is defined.
module tb_cell_sweep_ctrl;

  localparam int PAGE_W = 6;
  localparam int SEL_W  = 3;
  localparam int CNT_W  = 8;
  localparam int BUDGET = 400;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic [PAGE_W-1:0] page_first;
  logic [PAGE_W-1:0] page_last;
  logic [7:0]        sel_mask;
  logic [PAGE_W-1:0] cm_in_cfg;
  logic              abort;
  logic [PAGE_W-1:0] cm_page;
  logic [PAGE_W-1:0] cm_in;
  logic              ro_en;
  logic [SEL_W-1:0]  ro_sel;
  logic [CNT_W-1:0]  ro_count;
  logic              res_valid;
  logic              res_ready;
  logic [PAGE_W-1:0] res_page;
  logic [SEL_W-1:0]  res_sel;
  logic [CNT_W-1:0]  res_count;
  logic              busy;
  logic              done;

  int testsRun = 0;
  int testsFailed = 0;

  cell_sweep_ctrl dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .page_first(page_first),
    .page_last (page_last),
    .sel_mask  (sel_mask),
    .cm_in_cfg (cm_in_cfg),
`ifdef CELL_SWEEP_ABORT_EN
    .abort     (abort),
`endif
    .cm_page   (cm_page),
    .cm_in     (cm_in),
    .ro_en     (ro_en),
    .ro_sel    (ro_sel),
    .ro_count  (ro_count),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_page  (res_page),
    .res_sel   (res_sel),
    .res_count (res_count),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  // Cycle 0 is the cycle in which start is sampled; the monitor samples at each negedge.
  int cyc, busyCycles, roHigh, roPulses, firstRoCyc, selChangeErr, stableErr;
  int donePulses, doneCyc, cmInAtValid;
  int recPage[$], recSel[$], recCnt[$], acceptCyc[$], validRiseCyc[$];
  logic prevRoEn = 1'b0, prevValid = 1'b0, prevAcc = 1'b0;
  logic [SEL_W-1:0] prevRoSel = '0;
  logic [PAGE_W-1:0] prevCmPage = '0;
  logic [PAGE_W+SEL_W+CNT_W-1:0] prevRes = '0;

  always @(negedge clk) begin
    cyc++;
    if (busy) busyCycles++;
    if (ro_en) begin
      roHigh++;
      if (firstRoCyc < 0) firstRoCyc = cyc;
    end
    if (ro_en && !prevRoEn) roPulses++;
    if (ro_en && prevRoEn && (ro_sel != prevRoSel || cm_page != prevCmPage)) selChangeErr++;
    if (res_valid && !prevValid) begin
      validRiseCyc.push_back(cyc);
      cmInAtValid = int'(cm_in);
    end
    if (res_valid && prevValid && !prevAcc && ({res_page, res_sel, res_count} != prevRes)) stableErr++;
    if (res_valid && res_ready) begin
      recPage.push_back(int'(res_page));
      recSel.push_back(int'(res_sel));
      recCnt.push_back(int'(res_count));
      acceptCyc.push_back(cyc);
    end
    if (done) begin
      donePulses++;
      if (doneCyc < 0) doneCyc = cyc;
    end
    prevRoEn   = ro_en;
    prevRoSel  = ro_sel;
    prevCmPage = cm_page;
    prevValid  = res_valid;
    prevAcc    = res_valid && res_ready;
    prevRes    = {res_page, res_sel, res_count};
  end

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, actual, expected);
    end
  endtask

  task automatic clearMonitor();
    cyc = 0; busyCycles = 0; roHigh = 0; roPulses = 0; firstRoCyc = -1;
    selChangeErr = 0; stableErr = 0; donePulses = 0; doneCyc = -1; cmInAtValid = -1;
    recPage.delete(); recSel.delete(); recCnt.delete();
    acceptCyc.delete(); validRiseCyc.delete();
  endtask

  // Config is scrambled right after the start edge to show it was latched.
  task automatic applyStimulus(input int first, input int last, input int mask,
                               input int cfg, input int count, input logic ready);
    @(negedge clk);
    #1;
    page_first = PAGE_W'(first);
    page_last  = PAGE_W'(last);
    sel_mask   = 8'(mask);
    cm_in_cfg  = PAGE_W'(cfg);
    ro_count   = CNT_W'(count);
    res_ready  = ready;
    start      = 1'b1;
    clearMonitor();
    @(posedge clk);
    #1;
    start      = 1'b0;
    page_first = '0;
    page_last  = '0;
    sel_mask   = '0;
    cm_in_cfg  = '0;
  endtask

  task automatic waitDone(input string tag);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!done && n < BUDGET);
    if (!done) checkOutput({"timeout_", tag}, 32'd0, 32'd1);
    repeat (3) @(negedge clk);
  endtask

  function automatic int qAt(input int q[$], input int idx);
    return (idx < q.size()) ? q[idx] : -1;
  endfunction

  initial begin
    int expPage[4];
    int expSel[4];
    int n;
    rst = 1'b1; start = 1'b0; abort = 1'b0; res_ready = 1'b1;
    page_first = '0; page_last = '0; sel_mask = '0; cm_in_cfg = '0; ro_count = '0;
    clearMonitor();
    repeat (3) @(negedge clk);
    checkOutput("reset_cm_page", 32'(cm_page), 32'd0);
    checkOutput("reset_cm_in", 32'(cm_in), 32'd0);
    checkOutput("reset_ro", {30'd0, ro_en, 1'b0} | 32'(ro_sel), 32'd0);
    checkOutput("reset_res", {res_valid, 7'd0, 32'(res_page) + 32'(res_sel) + 32'(res_count)}, 32'd0);
    checkOutput("reset_busy_done", {30'd0, busy, done}, 32'd0);
    #1 rst = 1'b0;

    // Single page, single select.
    applyStimulus(5, 5, 8'h01, 6'h15, 8'h3C, 1'b1);
    waitDone("single");
    checkOutput("single_first_ro", 32'(firstRoCyc), 32'd5);
    checkOutput("single_ro_high", 32'(roHigh), 32'd16);
    checkOutput("single_ro_pulses", 32'(roPulses), 32'd1);
    checkOutput("single_valid_cyc", 32'(qAt(validRiseCyc, 0)), 32'd22);
    checkOutput("single_nrec", 32'(recPage.size()), 32'd1);
    checkOutput("single_rec", {8'(qAt(recPage, 0)), 8'(qAt(recSel, 0)), 16'(qAt(recCnt, 0))}, {8'd5, 8'd0, 16'h3C});
    checkOutput("single_done_cyc", 32'(doneCyc), 32'd23);
    checkOutput("single_done_pulses", 32'(donePulses), 32'd1);
    checkOutput("single_busy_cycles", 32'(busyCycles), 32'd23);
    checkOutput("single_busy_after", {31'd0, busy}, 32'd0);
    checkOutput("single_cm_in", 32'(cmInAtValid), 32'h15);

    // Two pages x two selects, no backpressure.
    expPage = '{2, 2, 3, 3};
    expSel  = '{1, 7, 1, 7};
    applyStimulus(2, 3, 8'h82, 6'h2A, 8'h11, 1'b1);
    waitDone("multi");
    checkOutput("multi_nrec", 32'(recPage.size()), 32'd4);
    for (int i = 0; i < 4; i++) begin
      checkOutput($sformatf("multi_page%0d", i), 32'(qAt(recPage, i)), 32'(expPage[i]));
      checkOutput($sformatf("multi_sel%0d", i), 32'(qAt(recSel, i)), 32'(expSel[i]));
    end
    checkOutput("multi_count3", 32'(qAt(recCnt, 3)), 32'h11);
    checkOutput("multi_ro_pulses", 32'(roPulses), 32'd4);
    checkOutput("multi_valid1_cyc", 32'(qAt(validRiseCyc, 1)), 32'd44);
    checkOutput("multi_done_cyc", 32'(doneCyc), 32'd89);
    checkOutput("multi_sel_change", 32'(selChangeErr), 32'd0);
    checkOutput("multi_cm_in", 32'(cmInAtValid), 32'h2A);

    // Same sweep with 10 cycles of backpressure on the first record.
    applyStimulus(2, 3, 8'h82, 6'h2A, 8'h22, 1'b0);
    n = 0;
    while (!res_valid && n < BUDGET) begin
      @(negedge clk);
      n++;
    end
    if (!res_valid) checkOutput("timeout_stall_valid", 32'd0, 32'd1);
    repeat (10) @(posedge clk);
    #1 res_ready = 1'b1;
    waitDone("stall");
    checkOutput("stall_stable", 32'(stableErr), 32'd0);
    checkOutput("stall_accept0", 32'(qAt(acceptCyc, 0)), 32'd32);
    checkOutput("stall_valid1_cyc", 32'(qAt(validRiseCyc, 1)), 32'd54);
    checkOutput("stall_nrec", 32'(recPage.size()), 32'd4);
    checkOutput("stall_rec0", {16'(qAt(recPage, 0)), 16'(qAt(recSel, 0))}, {16'd2, 16'd1});
    checkOutput("stall_ro_pulses", 32'(roPulses), 32'd4);
    checkOutput("stall_done_cyc", 32'(doneCyc), 32'd99);

    // Degenerate: inverted page range, then empty mask.
    applyStimulus(7, 3, 8'hFF, 6'h01, 8'h00, 1'b1);
    waitDone("inv");
    checkOutput("inv_done_cyc", 32'(doneCyc), 32'd1);
    checkOutput("inv_no_valid", 32'(validRiseCyc.size()), 32'd0);
    checkOutput("inv_no_ro", 32'(roPulses), 32'd0);
    checkOutput("inv_busy_cycles", 32'(busyCycles), 32'd1);
    applyStimulus(1, 4, 8'h00, 6'h01, 8'h00, 1'b1);
    waitDone("nomask");
    checkOutput("nomask_done_cyc", 32'(doneCyc), 32'd1);
    checkOutput("nomask_no_valid", 32'(validRiseCyc.size()), 32'd0);
    checkOutput("nomask_no_ro", 32'(roPulses), 32'd0);

    // Top of the page range must not wrap to page 0.
    applyStimulus(62, 63, 8'h01, 6'h00, 8'h5A, 1'b1);
    waitDone("top");
    checkOutput("top_nrec", 32'(recPage.size()), 32'd2);
    checkOutput("top_pages", {16'(qAt(recPage, 0)), 16'(qAt(recPage, 1))}, {16'd62, 16'd63});
    checkOutput("top_sels", {16'(qAt(recSel, 0)), 16'(qAt(recSel, 1))}, {16'd0, 16'd0});
    checkOutput("top_done_cyc", 32'(doneCyc), 32'd45);
    checkOutput("top_cm_page", 32'(cm_page), 32'd63);

    // Asynchronous reset while the gate window is open.
    applyStimulus(9, 9, 8'h04, 6'h07, 8'h44, 1'b1);
    n = 0;
    while (!ro_en && n < BUDGET) begin
      @(negedge clk);
      n++;
    end
    if (!ro_en) checkOutput("timeout_arm", 32'd0, 32'd1);
    @(posedge clk);
    #3 rst = 1'b1;
    #1;
    checkOutput("rst_ro_en", {31'd0, ro_en}, 32'd0);
    checkOutput("rst_busy", {31'd0, busy}, 32'd0);
    checkOutput("rst_res_valid", {31'd0, res_valid}, 32'd0);
    checkOutput("rst_cm_page_sel", {16'(cm_page), 16'(ro_sel)}, 32'd0);
    @(negedge clk);
    #1 rst = 1'b0;
    repeat (40) @(negedge clk);
    checkOutput("rst_no_rec", 32'(recPage.size()), 32'd0);
    checkOutput("rst_ro_pulses", 32'(roPulses), 32'd1);

`ifdef CELL_SWEEP_ABORT_EN
    // Abort raised in cycle 2 (SETUP) gives DONE in cycle 3 and no record.
    applyStimulus(1, 2, 8'h01, 6'h03, 8'h10, 1'b1);
    @(posedge clk);
    #1 abort = 1'b1;
    @(posedge clk);
    #1 abort = 1'b0;
    waitDone("abort");
    checkOutput("abort_done_cyc", 32'(doneCyc), 32'd3);
    checkOutput("abort_done_pulses", 32'(donePulses), 32'd1);
    checkOutput("abort_no_ro", 32'(roPulses), 32'd0);
    checkOutput("abort_no_valid", 32'(validRiseCyc.size()), 32'd0);
`endif

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
